// File: rtl/tcb_lite_pkg.sv
// Shared types and helpers for the TCB lite library blocks.
package tcb_lite_pkg;

  typedef enum logic {
    ARB_RR  = 1'b0,
    ARB_FIX = 1'b1
  } arb_mode_t;

  localparam int unsigned TCB_DAT_MAX = 64;
  localparam int unsigned TCB_ADR_MAX = 64;
  localparam int unsigned TCB_BYT_MAX = TCB_DAT_MAX / 8;
  localparam int unsigned TCB_SIZ_MAX = $clog2(TCB_BYT_MAX);

  typedef struct packed {
    logic                   lck;
    logic                   ndn;
    logic                   wen;
    logic [TCB_ADR_MAX-1:0] adr;
    logic [TCB_SIZ_MAX-1:0] siz;
    logic [TCB_BYT_MAX-1:0] byt;
    logic [TCB_DAT_MAX-1:0] wdt;
  } tcb_lite_req_t;

  // Number of bytes covered by a logarithmic transfer size.
  function automatic int unsigned siz2byt(input int unsigned siz);
    return 32'd1 << siz;
  endfunction

endpackage

// File: rtl/tcb_lite_lib_arb_rr.sv
// Combinational round-robin request arbiter; ptr=0 degenerates to fixed priority.
module tcb_lite_lib_arb_rr
  import tcb_lite_pkg::*;
#(
  parameter  int unsigned IFN = 2,
  localparam int unsigned IDX = $clog2(IFN)
)(
  input  logic [IFN-1:0] req,
  input  logic [IDX-1:0] ptr,
  output logic [IDX-1:0] gnt_idx,
  output logic           gnt_vld
);

  logic [IFN-1:0] msk;
  logic [IFN-1:0] req_hi;

  always_comb begin
    msk = '0;
    for (int unsigned i = 0; i < IFN; i++) begin
      msk[i] = (IDX'(i) >= ptr);
    end
    req_hi  = req & msk;
    gnt_vld = |req;
    gnt_idx = '0;
    // Descending scans let the lowest index win; requests at/after ptr override wrapped ones.
    for (int unsigned i = IFN; i > 0; i--) begin
      if (req[i-1]) gnt_idx = IDX'(i-1);
    end
    if (|req_hi) begin
      for (int unsigned i = IFN; i > 0; i--) begin
        if (req_hi[i-1]) gnt_idx = IDX'(i-1);
      end
    end
  end

endmodule

// File: rtl/tcb_lite_lib_arbiter.sv
// N-manager to 1-subordinate TCB lite arbiter with lock support and
// fixed-latency response routing through a grant-index delay line.
module tcb_lite_lib_arbiter
  import tcb_lite_pkg::*;
#(
  parameter  int unsigned IFN = 2,
  parameter  int unsigned DLY = 1,
  parameter  int unsigned DAT = 32,
  parameter  int unsigned ADR = 32,
  parameter  logic        PRI = 1'b0,
  localparam int unsigned BYT = DAT/8,
  localparam int unsigned SIZ = $clog2(DAT/8),
  localparam int unsigned IDX = $clog2(IFN)
)(
  input  logic               clk,
  input  logic               rst,
  input  logic [IFN-1:0]     man_vld,
  output logic [IFN-1:0]     man_rdy,
  input  logic [IFN-1:0]     man_lck,
  input  logic [IFN-1:0]     man_ndn,
  input  logic [IFN-1:0]     man_wen,
  input  logic [IFN*ADR-1:0] man_adr,
  input  logic [IFN*SIZ-1:0] man_siz,
  input  logic [IFN*BYT-1:0] man_byt,
  input  logic [IFN*DAT-1:0] man_wdt,
  output logic [IFN*DAT-1:0] man_rdt,
  output logic [IFN-1:0]     man_err,
  output logic               sub_vld,
  input  logic               sub_rdy,
  output logic               sub_lck,
  output logic               sub_ndn,
  output logic               sub_wen,
  output logic [ADR-1:0]     sub_adr,
  output logic [SIZ-1:0]     sub_siz,
  output logic [BYT-1:0]     sub_byt,
  output logic [DAT-1:0]     sub_wdt,
  input  logic [DAT-1:0]     sub_rdt,
  input  logic               sub_err,
  output logic [IDX-1:0]     sub_sel
);

  logic [IDX-1:0] ptr;
  logic [IDX-1:0] own;
  logic           lkd;
  logic           hld;
  logic [IDX-1:0] hsel;
  logic [IDX-1:0] arb_ptr;
  logic [IDX-1:0] arb_idx;
  logic           arb_vld;
  logic [IDX-1:0] gnt;
  logic           gnt_vld;
  logic           trn;
  logic [IDX-1:0] nxt;
  logic           dly_trn;
  logic [IDX-1:0] dly_sel;

  assign arb_ptr = (PRI == ARB_FIX) ? '0 : ptr;

  tcb_lite_lib_arb_rr #(
    .IFN (IFN)
  ) u_arb (
    .req     (man_vld),
    .ptr     (arb_ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Lock owner wins unconditionally; a stalled, still-valid manager keeps its grant.
  always_comb begin
    gnt     = arb_idx;
    gnt_vld = arb_vld;
    if (lkd) begin
      gnt     = own;
      gnt_vld = 1'b1;
    end else if (hld && man_vld[hsel]) begin
      gnt     = hsel;
      gnt_vld = 1'b1;
    end
  end

  assign sub_vld = gnt_vld & man_vld[gnt];
  assign sub_lck = man_lck[gnt];
  assign sub_ndn = man_ndn[gnt];
  assign sub_wen = man_wen[gnt];
  assign sub_adr = man_adr[gnt*ADR +: ADR];
  assign sub_siz = man_siz[gnt*SIZ +: SIZ];
  assign sub_byt = man_byt[gnt*BYT +: BYT];
  assign sub_wdt = man_wdt[gnt*DAT +: DAT];
  assign sub_sel = gnt;
  assign trn     = sub_vld & sub_rdy;
  assign nxt     = (gnt == IDX'(IFN-1)) ? '0 : gnt + 1'b1;
  assign man_rdt = {IFN{sub_rdt}};

  always_comb begin
    man_rdy = '0;
    for (int unsigned i = 0; i < IFN; i++) begin
      man_rdy[i] = sub_rdy & gnt_vld & (gnt == IDX'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr  <= '0;
      lkd  <= 1'b0;
      own  <= '0;
      hld  <= 1'b0;
      hsel <= '0;
    end else begin
      hld  <= sub_vld & ~sub_rdy;
      hsel <= gnt;
      if (trn) begin
        if (sub_lck) begin
          lkd <= 1'b1;
          own <= gnt;
        end else begin
          lkd <= 1'b0;
          if (PRI == ARB_RR) ptr <= nxt;
        end
      end
    end
  end

  if (DLY == 0) begin : g_nodly
    assign dly_trn = trn;
    assign dly_sel = gnt;
  end else begin : g_dly
    logic [DLY:1]   trn_dly;
    logic [IDX-1:0] sel_dly [1:DLY];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        trn_dly <= '0;
        for (int unsigned i = 1; i <= DLY; i++) sel_dly[i] <= '0;
      end else begin
        trn_dly[1] <= trn;
        sel_dly[1] <= gnt;
        for (int unsigned i = 2; i <= DLY; i++) begin
          trn_dly[i] <= trn_dly[i-1];
          sel_dly[i] <= sel_dly[i-1];
        end
      end
    end

    assign dly_trn = trn_dly[DLY];
    assign dly_sel = sel_dly[DLY];
  end

  always_comb begin
    man_err = '0;
    for (int unsigned i = 0; i < IFN; i++) begin
      man_err[i] = sub_err & dly_trn & (dly_sel == IDX'(i));
    end
  end

endmodule

// File: doc/tcb_lite_lib_arbiter.md
Name: tcb_lite_lib_arbiter

Overview:
- N-manager to 1-subordinate TCB lite arbiter/multiplexer. It is the multi-channel successor of the single-channel TCB lite link.
- Arbitrates request channels by round-robin or fixed priority, and honours the `lck` arbitration lock.
- Routes each fixed-latency response back to the originating manager through a `DLY`-deep grant-index delay line.
- Sits between CPU/DMA/debug managers and a shared memory or peripheral subordinate.

Parameters:
- IFN, 2, number of manager channels (2..16)
- DLY, 1, subordinate response delay in cycles (0..4); must match the subordinate
- DAT, 32, data width (32 or 64)
- ADR, 32, address width
- BYT, DAT/8, byte enable width (derived, localparam)
- SIZ, $clog2(DAT/8), logarithmic size width (derived, localparam)
- PRI, 1'b0, arbitration mode (0 = round-robin, 1 = fixed priority, index 0 highest)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- man_vld  input  IFN  request valid per manager
- man_rdy  output  IFN  ready per manager
- man_lck  input  IFN  arbitration lock per manager
- man_ndn  input  IFN  endianness per manager
- man_wen  input  IFN  write enable per manager
- man_adr  input  IFN x ADR  address
- man_siz  input  IFN x SIZ  logarithmic size
- man_byt  input  IFN x BYT  byte enable
- man_wdt  input  IFN x DAT  write data
- man_rdt  output  IFN x DAT  read data (broadcast)
- man_err  output  IFN  bus error, owner only
- sub_vld  output  1  request valid
- sub_rdy  input  1  ready
- sub_lck, sub_ndn, sub_wen, sub_adr, sub_siz, sub_byt, sub_wdt  output  as manager  muxed request
- sub_rdt  input  DAT  read data
- sub_err  input  1  bus error
- sub_sel  output  $clog2(IFN)  current grant index (debug/monitor)

Behaviour:
- The clock is `clk`; the reset is `rst`, asynchronous and active-low. All state clears on `rst`=0 regardless of `clk`.
- State after reset:
  - round-robin pointer `ptr`=0
  - lock flag `lkd`=0, lock owner `own`=0
  - delay-line valid bits `trn_dly`[1..DLY]=0, index stages `sel_dly`[1..DLY]=0
- Outputs in reset:
  - `sub_vld`=0 when no `man_vld` is set.
  - `man_rdy` is all 0 unless `sub_rdy` is high and a manager is granted.
  - `man_err`=0.
- Grant is combinational, with zero added request latency:
  - If `lkd`=1: grant=`own` unconditionally. Other managers stall even if `own` drops `vld`.
  - Else, PRI=1: lowest-index active `man_vld`.
  - Else, PRI=0: first active `man_vld` searching `ptr`, `ptr`+1, ... modulo IFN.
- Mux and handshake:
  - `sub_vld` = `man_vld`[grant] (0 if no request).
  - All `sub_*` request fields = `man_*`[grant].
  - `man_rdy`[i] = `sub_rdy` & (grant==i).
  - `sub_sel` = grant.
  - A transfer is `trn` = `sub_vld` & `sub_rdy`.
- Pointer update on `trn`: if PRI=0 and the transfer is unlocked, `ptr` <= (grant+1) mod IFN, wrapping at IFN-1 to 0. The pointer is frozen while locked.
- Lock update:
  - On `trn` with `sub_lck`=1: `lkd`<=1, `own`<=grant.
  - On `trn` with `sub_lck`=0: `lkd`<=0, and the pointer advances past `own`.
  - A lock without a transfer has no effect.
- Request stability: a manager must hold its request while stalled. The arbiter never switches grant away from a stalled, still-valid manager; the grant is held until `trn`.
- Response routing:
  - `sel_dly`[0]=grant and `trn_dly`[0]=`trn`, shifted every cycle through stages 1..DLY.
  - `man_rdt`[i] = `sub_rdt` for all i.
  - `man_err`[i] = `sub_err` & `trn_dly`[DLY] & (`sel_dly`[DLY]==i).
  - DLY=0 is purely combinational.
- Back-to-back transfers from different managers in consecutive cycles must route each response correctly; the delay line sustains full throughput.
- Reset mid-operation clears the lock and flushes the delay line; outstanding responses are dropped.

Decomposition:
- Package `tcb_lite_pkg`: the mode enum (PRI values), the `siz2byt` helper, and a `tcb_lite_req_t` struct (`lck`, `ndn`, `wen`, `adr`, `siz`, `byt`, `wdt`) parameterised via localparams.
- One sub-module, `tcb_lite_lib_arb_rr`: the IFN-wide request vector plus `ptr` in, one-hot/index grant out. It is combinational and reused by the future decoder/crossbar.
- Pointer, lock and delay line stay in the top.

Test Plan (IFN=3, DLY=1 unless stated):
- Round-robin: all three `man_vld`=1 and `sub_rdy`=1 for 6 cycles -> grants 0,1,2,0,1,2; each `man_err` pulses only one cycle after its own transfer when `sub_err`=1.
- Fixed priority, PRI=1: `man_vld`=3'b110 -> grant 1 every cycle; manager 2 starved; `sub_adr`=`man_adr`[1].
- Lock:
  - Manager 2 transfers with `lck`=1, then drops `vld` for 2 cycles while managers 0/1 request -> `man_rdy`[1:0]=0 and `sub_vld`=0.
  - Manager 2 then issues `lck`=0 -> the lock releases and the next grant goes to manager 0.
- Stall: `sub_rdy`=0 for 3 cycles while managers 0 and 1 are valid -> grant stays 0; the first `trn` is on `sub_rdy` rise, then the grant moves to 1.
- Routing with DLY=3: transfers from managers 1,0,2 back-to-back with `sub_err` pattern 1,0,1 delayed 3 cycles -> `man_err`[1] then `man_err`[2] assert, `man_err`[0] stays 0.
- Reset: assert `rst`=0 asynchronously mid-lock with 1 transfer in flight -> `sub_vld` follows the unlocked arbitration immediately, `man_err` stays 0, and after release the grant starts from `ptr`=0.
